// File: rtl/tvs_pkg.sv
// Shared types and constants for the test-vector sequencer.
package tvs_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSettle,
        StCapture,
        StDone
    } tvs_state_e;

    localparam int unsigned        MISR_W    = 16;
    localparam logic [MISR_W-1:0]  MISR_POLY = 16'h6801;
    localparam logic [MISR_W-1:0]  MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/tvs_misr.sv
// 16-bit multiple-input signature register over the captured CUT responses.
module tvs_misr
    import tvs_pkg::*;
#(
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic [MISR_W-1:0] sig
);

    localparam int unsigned IDX_W = $clog2(MISR_W);

    logic [MISR_W-1:0] sig_q, sig_d, fold;

    // Fold inputs wider than the register back onto its low bits.
    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fold[IDX_W'(i % MISR_W)] = fold[IDX_W'(i % MISR_W)] ^ data_in[i];
        end
    end

    // Seed on init, otherwise shift-and-compress one response per strobe.
    always_comb begin
        sig_d = sig_q;
        if (init) begin
            sig_d = MISR_SEED;
        end else if (shift) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0) ^ fold;
        end
    end

    // Signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/test_vector_sequencer.sv
// Replays stored stimulus/response pairs into a combinational CUT and scores
// the results. Define TVS_MISR_EN to add a response signature output.
module test_vector_sequencer
    import tvs_pkg::*;
#(
    parameter int unsigned  IN_W          = 5,
    parameter int unsigned  OUT_W         = 2,
    parameter int unsigned  NUM_TESTS     = 32,
    parameter int unsigned  SETTLE_CYCLES = 1,
    localparam int unsigned ADDR_W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int unsigned CNT_W         = $clog2(NUM_TESTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IN_W-1:0]   mem_vec,
    input  logic [OUT_W-1:0]  mem_exp,
    output logic [IN_W-1:0]   cut_in,
    input  logic [OUT_W-1:0]  cut_out,
    output logic [CNT_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx
`ifdef TVS_MISR_EN
    ,
    output logic [MISR_W-1:0] signature
`endif
);

    localparam int unsigned       SET_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TESTS - 1);

    tvs_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, mem_addr_q, mem_addr_d, first_fail_q, first_fail_d;
    logic [IN_W-1:0]   cut_in_q, cut_in_d;
    logic [OUT_W-1:0]  exp_q, exp_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              fail_valid_q, fail_valid_d, pass_q, pass_d, done_q, done_d;
    logic              start_ok;

    // Next-state and datapath updates for the replay FSM.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mem_addr_d   = mem_addr_q;
        first_fail_d = first_fail_q;
        cut_in_d     = cut_in_q;
        exp_d        = exp_q;
        settle_d     = settle_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        done_d       = done_q;
        start_ok     = 1'b0;
        mem_rd       = 1'b0;

        case (state_q)
            StIdle: begin
                start_ok = start;
            end
            StFetch: begin
                mem_rd  = 1'b1;
                state_d = StLoad;
            end
            StLoad: begin
                cut_in_d = mem_vec;
                exp_d    = mem_exp;
                settle_d = SET_W'(SETTLE_CYCLES);
                state_d  = (SETTLE_CYCLES == 0) ? StCapture : StSettle;
            end
            StSettle: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q <= SET_W'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (cut_out != exp_q) begin
                    err_count_d = err_count_q + CNT_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                    pass_d  = (err_count_d == '0);
                end else begin
                    idx_d      = idx_q + ADDR_W'(1);
                    mem_addr_d = idx_q + ADDR_W'(1);
                    state_d    = StFetch;
                end
            end
            StDone: begin
                // done lags DONE entry by one cycle; a restart waits for it.
                done_d   = 1'b1;
                start_ok = start && done_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_ok) begin
            state_d      = StFetch;
            idx_d        = '0;
            mem_addr_d   = '0;
            err_count_d  = '0;
            fail_valid_d = 1'b0;
            first_fail_d = '0;
            pass_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            mem_addr_q   <= '0;
            first_fail_q <= '0;
            cut_in_q     <= '0;
            exp_q        <= '0;
            settle_q     <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mem_addr_q   <= mem_addr_d;
            first_fail_q <= first_fail_d;
            cut_in_q     <= cut_in_d;
            exp_q        <= exp_d;
            settle_q     <= settle_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    // Status outputs.
    always_comb begin
        busy = state_q inside {StFetch, StLoad, StSettle, StCapture};
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign mem_addr       = mem_addr_q;
    assign cut_in         = cut_in_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_q;

`ifdef TVS_MISR_EN
    tvs_misr #(
        .DATA_W (OUT_W)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .init    (start_ok),
        .shift   (state_q == StCapture),
        .data_in (cut_out),
        .sig     (signature)
    );
`endif

endmodule
